// File: rtl/servo_pkg.sv
// Shared types for the arm servo sequencers: select codes, command codes,
// step encoding, FSM states and the per-command step lookup.
package servo_pkg;

  localparam logic [1:0] ROT_NEG     = 2'b00;
  localparam logic [1:0] ROT_CTR     = 2'b01;
  localparam logic [1:0] ROT_POS     = 2'b10;
  localparam logic [1:0] GRIP_OPEN   = 2'b00;
  localparam logic [1:0] GRIP_CLOSED = 2'b10;

  typedef enum logic [1:0] {
    CMD_CW   = 2'b00,
    CMD_CCW  = 2'b01,
    CMD_HALF = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_e;

  typedef enum logic {
    SERVO_ROT  = 1'b0,
    SERVO_GRIP = 1'b1
  } servo_e;

  typedef struct packed {
    servo_e     servo;
    logic [1:0] sel;
  } step_t;

  typedef struct packed {
    step_t step;
    logic  last;
  } rom_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_STEP,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_e;

  function automatic step_t mk(input servo_e servo, input logic [1:0] sel);
    step_t s;
    s.servo = servo;
    s.sel   = sel;
    return s;
  endfunction

  function automatic rom_entry_t step_rom(input cmd_e cmd, input logic [2:0] idx);
    rom_entry_t e;
    e.step = mk(SERVO_ROT, ROT_CTR);
    e.last = 1'b1;
    case (cmd)
      CMD_CW: begin
        e.last = (idx >= 3'd3);
        case (idx)
          3'd0:    e.step = mk(SERVO_ROT, ROT_POS);
          3'd1:    e.step = mk(SERVO_GRIP, GRIP_OPEN);
          3'd2:    e.step = mk(SERVO_ROT, ROT_CTR);
          default: e.step = mk(SERVO_GRIP, GRIP_CLOSED);
        endcase
      end
      CMD_CCW: begin
        e.last = (idx >= 3'd3);
        case (idx)
          3'd0:    e.step = mk(SERVO_ROT, ROT_NEG);
          3'd1:    e.step = mk(SERVO_GRIP, GRIP_OPEN);
          3'd2:    e.step = mk(SERVO_ROT, ROT_CTR);
          default: e.step = mk(SERVO_GRIP, GRIP_CLOSED);
        endcase
      end
      CMD_HALF: begin
        e.last = (idx >= 3'd6);
        case (idx)
          3'd0:    e.step = mk(SERVO_GRIP, GRIP_OPEN);
          3'd1:    e.step = mk(SERVO_ROT, ROT_NEG);
          3'd2:    e.step = mk(SERVO_GRIP, GRIP_CLOSED);
          3'd3:    e.step = mk(SERVO_ROT, ROT_POS);
          3'd4:    e.step = mk(SERVO_GRIP, GRIP_OPEN);
          3'd5:    e.step = mk(SERVO_ROT, ROT_CTR);
          default: e.step = mk(SERVO_GRIP, GRIP_CLOSED);
        endcase
      end
      default: begin
        e.step = mk(SERVO_ROT, ROT_CTR);
        e.last = 1'b1;
      end
    endcase
    return e;
  endfunction

endpackage

// File: rtl/servo_move_sequencer_if.sv
// Command handshake from the move planner plus the two servo selects and
// status pulses of one arm.
interface servo_move_sequencer_if;
  import servo_pkg::*;

  logic       cmd_valid;
  logic [1:0] cmd;
  logic       cmd_ready;
  logic [1:0] rot_sel;
  logic [1:0] grip_sel;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output cmd_valid, cmd,
    input  cmd_ready, rot_sel, grip_sel, busy, done, err
  );

  modport slave (
    input  cmd_valid, cmd,
    output cmd_ready, rot_sel, grip_sel, busy, done, err
  );

endinterface

// File: rtl/settle_timer.sv
// Load/expire down-counter: load restarts a T_SETTLE-cycle hold, expired is
// high once the count has reached zero; it never wraps.
module settle_timer #(
  parameter int unsigned T_SETTLE = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  output logic expired
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = 32'(T_SETTLE - 1);
    end else if (count_q != 32'd0) begin
      count_d = count_q - 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == 32'd0);

endmodule

// File: rtl/servo_move_sequencer.sv
// Steps the rotation and gripper selects of one arm through a face-turn
// sequence, holding every step for T_SETTLE cycles before the next.
//
// state | meaning
// IDLE  | rest pose, ready for a command
// STEP  | command latched; applies step 0 (or diverts a reserved command to ERR)
// WAIT  | settling; on expiry the next step is applied directly so steps stay T_SETTLE apart
// DONE  | done pulse; still ready, so a back-to-back command is taken here
// ERR   | err pulse for a reserved command; servos untouched
module servo_move_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned T_SETTLE = 25_000_000
) (
  input logic                   clock,
  input logic                   reset,
  servo_move_sequencer_if.slave bus
);

  state_e     state_q, state_d;
  cmd_e       cmd_q, cmd_d;
  logic [2:0] idx_q, idx_d;
  logic       last_q, last_d;
  logic [1:0] rot_q, rot_d;
  logic [1:0] grip_q, grip_d;
  logic       load, expired, apply;
  rom_entry_t cur;

  settle_timer #(.T_SETTLE(T_SETTLE)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .load    (load),
    .expired (expired)
  );

  // idx_q always points at the next step to apply
  assign cur = step_rom(cmd_q, idx_q);

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    last_d  = last_q;
    rot_d   = rot_q;
    grip_d  = grip_q;
    load    = 1'b0;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.cmd_valid) begin
          cmd_d   = cmd_e'(bus.cmd);
          idx_d   = 3'd0;
          last_d  = 1'b0;
          state_d = ST_STEP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (cmd_q == CMD_RSVD) begin
          state_d = ST_ERR;
        end else begin
          apply   = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (expired) begin
          if (last_q) state_d = ST_DONE;
          else        apply   = 1'b1;
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (apply) begin
      load   = 1'b1;
      idx_d  = idx_q + 3'd1;
      last_d = cur.last;
      if (cur.step.servo == SERVO_GRIP) grip_d = cur.step.sel;
      else                              rot_d  = cur.step.sel;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_CW;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      rot_q   <= ROT_CTR;
      grip_q  <= GRIP_CLOSED;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      rot_q   <= rot_d;
      grip_q  <= grip_d;
    end
  end

  assign bus.cmd_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign bus.busy      = (state_q == ST_WAIT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = (state_q == ST_ERR);
  assign bus.rot_sel   = rot_q;
  assign bus.grip_sel  = grip_q;

endmodule

// File: tb/tb_servo_move_sequencer.sv
// Bench for servo_move_sequencer: two instances (T_SETTLE 4 and 1) driven with
// directed and random commands, compared against a step-replay pose model.
module tb_servo_move_sequencer;

  logic       clk;
  logic       rst;
  logic       vld   [2];
  logic [1:0] cmdv  [2];
  logic [1:0] rot_o [2];
  logic [1:0] grip_o[2];
  logic       ready_o[2];
  logic       busy_o [2];
  logic       done_o [2];
  logic       err_o  [2];

  int passed = 0;
  int total  = 0;

  servo_move_sequencer_if bus4 ();
  servo_move_sequencer_if bus1 ();

  assign bus4.cmd_valid = vld[0];
  assign bus4.cmd       = cmdv[0];
  assign bus1.cmd_valid = vld[1];
  assign bus1.cmd       = cmdv[1];

  assign rot_o[0]   = bus4.rot_sel;
  assign grip_o[0]  = bus4.grip_sel;
  assign ready_o[0] = bus4.cmd_ready;
  assign busy_o[0]  = bus4.busy;
  assign done_o[0]  = bus4.done;
  assign err_o[0]   = bus4.err;
  assign rot_o[1]   = bus1.rot_sel;
  assign grip_o[1]  = bus1.grip_sel;
  assign ready_o[1] = bus1.cmd_ready;
  assign busy_o[1]  = bus1.busy;
  assign done_o[1]  = bus1.done;
  assign err_o[1]   = bus1.err;

  servo_move_sequencer #(.T_SETTLE(4)) u_dut4 (
    .clock (clk),
    .reset (rst),
    .bus   (bus4.slave)
  );

  servo_move_sequencer #(.T_SETTLE(1)) u_dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a command is a list of servo moves; the pose after edge k
  // is the rest pose with every move due by then (move n due at 1 + n*t) applied.
  function automatic int nsteps(input logic [1:0] c);
    return (c == 2'b10) ? 7 : 4;
  endfunction

  // returns {is_grip, select}
  function automatic logic [2:0] step_of(input logic [1:0] c, input int n);
    case (c)
      2'b00:
        case (n)
          0: return 3'b0_10;
          1: return 3'b1_00;
          2: return 3'b0_01;
          default: return 3'b1_10;
        endcase
      2'b01:
        case (n)
          0: return 3'b0_00;
          1: return 3'b1_00;
          2: return 3'b0_01;
          default: return 3'b1_10;
        endcase
      default:
        case (n)
          0: return 3'b1_00;
          1: return 3'b0_00;
          2: return 3'b1_10;
          3: return 3'b0_10;
          4: return 3'b1_00;
          5: return 3'b0_01;
          default: return 3'b1_10;
        endcase
    endcase
  endfunction

  // returns {rot, grip}
  function automatic logic [3:0] exp_pose(input logic [1:0] c, input int t, input int k);
    logic [1:0] r;
    logic [1:0] g;
    logic [2:0] s;
    r = 2'b01;
    g = 2'b10;
    if (c != 2'b11) begin
      for (int n = 0; n < nsteps(c); n++) begin
        if (1 + n * t <= k) begin
          s = step_of(c, n);
          if (s[2]) g = s[1:0];
          else      r = s[1:0];
        end
      end
    end
    return {r, g};
  endfunction

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_all(input int d, input string tag, input logic [3:0] pose,
                         input bit eb, input bit ed, input bit er, input bit ee);
    chk({tag, " rot"},   rot_o[d],             pose[3:2]);
    chk({tag, " grip"},  grip_o[d],            pose[1:0]);
    chk({tag, " busy"},  {1'b0, busy_o[d]},    {1'b0, eb});
    chk({tag, " done"},  {1'b0, done_o[d]},    {1'b0, ed});
    chk({tag, " ready"}, {1'b0, ready_o[d]},   {1'b0, er});
    chk({tag, " err"},   {1'b0, err_o[d]},     {1'b0, ee});
  endtask

  // Caller has presented command c; it is accepted at the next posedge (edge 0).
  // Inputs are scrambled while the DUT is not ready; in the final ready cycle
  // the next command is presented if chain is set.
  task automatic run_seq(input int d, input logic [1:0] c, input int t,
                         input bit chain, input logic [1:0] nc);
    int kend;
    bit eb, ed, er, ee;
    kend = (c == 2'b11) ? 2 : nsteps(c) * t + 1;
    @(posedge clk);
    for (int k = 0; k <= kend; k++) begin
      if (k > 0) @(posedge clk);
      @(negedge clk);
      if (c == 2'b11) begin
        eb = 1'b0; ed = 1'b0; ee = (k == 1); er = (k == 2);
      end else begin
        eb = (k >= 1) && (k <= kend - 1);
        ed = (k == kend);
        er = (k == kend);
        ee = 1'b0;
      end
      chk_all(d, $sformatf("d%0d c%0d t%0d k%0d", d, c, t, k), exp_pose(c, t, k), eb, ed, er, ee);
      if (k < kend) begin
        vld[d]  = 1'($urandom_range(0, 1));
        cmdv[d] = 2'($urandom_range(0, 3));
      end else begin
        vld[d]  = chain;
        cmdv[d] = nc;
      end
    end
  endtask

  task automatic random_runs(input int d, input int t, input int n);
    logic [1:0] c;
    logic [1:0] nc;
    bit ch;
    @(negedge clk);
    c = 2'($urandom_range(0, 3));
    vld[d]  = 1'b1;
    cmdv[d] = c;
    for (int i = 0; i < n; i++) begin
      nc = 2'($urandom_range(0, 3));
      ch = (i < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_seq(d, c, t, ch, nc);
      if (!ch && i < n - 1) begin
        @(negedge clk);
        chk($sformatf("d%0d idle ready", d), {1'b0, ready_o[d]}, 2'b01);
        vld[d]  = 1'b1;
        cmdv[d] = nc;
      end
      c = nc;
    end
  endtask

  initial begin
    logic [3:0] p;
    rst = 1'b0;
    vld[0] = 1'b0; vld[1] = 1'b0;
    cmdv[0] = 2'b00; cmdv[1] = 2'b00;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 2; d++) chk_all(d, $sformatf("reset d%0d", d), 4'b01_10, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // directed, T_SETTLE = 4
    vld[0] = 1'b1; cmdv[0] = 2'b00;
    run_seq(0, 2'b00, 4, 1'b0, 2'b00);
    @(negedge clk);
    vld[0] = 1'b1; cmdv[0] = 2'b10;
    run_seq(0, 2'b10, 4, 1'b0, 2'b00);
    @(negedge clk);
    vld[0] = 1'b1; cmdv[0] = 2'b11;
    run_seq(0, 2'b11, 4, 1'b0, 2'b00);
    @(negedge clk);
    vld[0] = 1'b1; cmdv[0] = 2'b01;
    run_seq(0, 2'b01, 4, 1'b1, 2'b01);
    run_seq(0, 2'b01, 4, 1'b0, 2'b00);

    random_runs(0, 4, 8);

    // reset at edge 7 of a half turn
    @(negedge clk);
    vld[0] = 1'b1; cmdv[0] = 2'b10;
    @(posedge clk);
    #1 vld[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    p = exp_pose(2'b10, 4, 7);
    chk("pre-reset rot", rot_o[0], p[3:2]);
    chk("pre-reset grip", grip_o[0], p[1:0]);
    #1 rst = 1'b1;
    #1;
    chk_all(0, "mid reset", 4'b01_10, 0, 0, 1, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_all(0, $sformatf("post reset %0d", i), 4'b01_10, 0, 0, 1, 0);
    end
    vld[0] = 1'b1; cmdv[0] = 2'b00;
    run_seq(0, 2'b00, 4, 1'b0, 2'b00);

    // T_SETTLE = 1
    @(negedge clk);
    vld[1] = 1'b1; cmdv[1] = 2'b00;
    run_seq(1, 2'b00, 1, 1'b0, 2'b00);
    random_runs(1, 1, 6);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
